// File: rtl/div_seq_ctrl_pkg.sv
// Shared definitions for the HI/LO divide sequencer: op encodings, FSM states
// and the default divider iteration count.
package div_seq_ctrl_pkg;

    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_MTHI = 2'd2;
    localparam logic [1:0] OP_MTLO = 2'd3;

    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/div_seq_ctrl_sign_fix.sv
// Restores the sign of the unsigned divider result: quotient takes the XOR of
// operand signs, remainder takes the dividend sign.
module div_sign_fix (
    input  logic [31:0] i_quo,
    input  logic [31:0] i_rem,
    input  logic        i_neg_q,
    input  logic        i_neg_r,
    output logic [31:0] o_q,
    output logic [31:0] o_r
);

    assign o_q = i_neg_q ? (32'd0 - i_quo) : i_quo;
    assign o_r = i_neg_r ? (32'd0 - i_rem) : i_rem;

endmodule

// File: rtl/div_seq_ctrl.sv
// Owns HI/LO and sequences the external iterative unsigned divider for
// DIV/DIVU, plus direct MTHI/MTLO writes.
module div_seq_ctrl #(
    parameter int DIV_ITERS = div_seq_ctrl_pkg::DIV_ITERS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_op_valid,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_op_a,
    input  logic [31:0] i_op_b,
    output logic        o_busy,
    output logic        o_div_zero,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_div_go,
    output logic [31:0] o_div_a,
    output logic [31:0] o_div_b,
    input  logic [31:0] i_div_quo,
    input  logic [31:0] i_div_rem,
    input  logic        i_div_ok
);
    import div_seq_ctrl_pkg::*;

    localparam int CW = $clog2(DIV_ITERS + 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_neg_q;
    logic          r_neg_r;
    logic          r_div_zero;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic [31:0]   r_div_a;
    logic [31:0]   r_div_b;

    logic          w_is_div;
    logic          w_signed;
    logic          w_neg_a;
    logic          w_neg_b;
    logic [31:0]   w_q_fix;
    logic [31:0]   w_r_fix;

    assign w_is_div = (i_op == OP_DIV) || (i_op == OP_DIVU);
    assign w_signed = (i_op == OP_DIV);
    assign w_neg_a  = w_signed & i_op_a[31];
    assign w_neg_b  = w_signed & i_op_b[31];

    div_sign_fix u_sign_fix (
        .i_quo   (i_div_quo),
        .i_rem   (i_div_rem),
        .i_neg_q (r_neg_q),
        .i_neg_r (r_neg_r),
        .o_q     (w_q_fix),
        .o_r     (w_r_fix)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_a    <= '0;
            r_div_b    <= '0;
        end else begin
            r_div_zero <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_op_valid) begin
                        if (i_op == OP_MTHI) begin
                            r_hi <= i_op_a;
                        end else if (i_op == OP_MTLO) begin
                            r_lo <= i_op_a;
                        end else if (w_is_div && (i_op_b == 32'd0)) begin
                            r_div_zero <= 1'b1;
                        end else begin
                            // -0x80000000 wraps to itself, which is the correct magnitude.
                            r_neg_q <= w_neg_a ^ w_neg_b;
                            r_neg_r <= w_neg_a;
                            r_div_a <= w_neg_a ? (32'd0 - i_op_a) : i_op_a;
                            r_div_b <= w_neg_b ? (32'd0 - i_op_b) : i_op_b;
                            r_cnt   <= '0;
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    // One load edge plus DIV_ITERS iteration edges.
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(DIV_ITERS))
                        r_state <= WAIT;
                end
                WAIT: begin
                    if (i_div_ok) begin
                        r_lo    <= w_q_fix;
                        r_hi    <= w_r_fix;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy     = (r_state != IDLE);
    assign o_div_go   = (r_state == RUN);
    assign o_div_zero = r_div_zero;
    assign o_hi       = r_hi;
    assign o_lo       = r_lo;
    assign o_div_a    = r_div_a;
    assign o_div_b    = r_div_b;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl with a behavioural divider standing in for
// the real iterative unit.
module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [1:0]  op;
    logic [31:0] op_a, op_b;
    logic        busy, div_zero, div_go;
    logic [31:0] hi, lo, div_a, div_b;
    logic [31:0] div_quo, div_rem;
    logic        div_ok;

    int n_chk  = 0;
    int n_fail = 0;
    int busy_cyc, go_cyc;
    bit zero_seen, go_seen;

    always #5 clk = ~clk;

    div_seq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .i_op_valid (op_valid),
        .i_op       (op),
        .i_op_a     (op_a),
        .i_op_b     (op_b),
        .o_busy     (busy),
        .o_div_zero (div_zero),
        .o_hi       (hi),
        .o_lo       (lo),
        .o_div_go   (div_go),
        .o_div_a    (div_a),
        .o_div_b    (div_b),
        .i_div_quo  (div_quo),
        .i_div_rem  (div_rem),
        .i_div_ok   (div_ok)
    );

    // Result is ready whenever the divider is not being driven.
    always_comb begin
        div_quo = (div_b != 32'd0) ? div_a / div_b : 32'hFFFF_FFFF;
        div_rem = (div_b != 32'd0) ? div_a % div_b : div_a;
        div_ok  = ~div_go;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; op_a = a; op_b = b; op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
    endtask

    // Counts busy and div_go cycles until busy drops, bounded.
    task automatic wait_done();
        busy_cyc = 0; go_cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cyc++;
            if (div_go) go_cyc++;
        end
        if (busy) chk("timeout", 32'(busy), 32'd0);
    endtask

    task automatic do_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        issue(o, a, b);
        wait_done();
    endtask

    initial begin
        reset = 1'b1; op_valid = 1'b0; op = 2'd0; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_go", 32'(div_go), 0);
        chk("rst_zero", 32'(div_zero), 0);
        chk("rst_diva", div_a, 0);
        reset = 1'b0;

        do_div(2'd1, 32'd100, 32'd7);
        chk("divu_busy_cyc", busy_cyc, 34);
        chk("divu_go_cyc", go_cyc, 33);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        do_div(2'd0, 32'hFFFF_FFF9, 32'd2);
        chk("div_n7_2_lo", lo, 32'hFFFF_FFFD);
        chk("div_n7_2_hi", hi, 32'hFFFF_FFFF);

        do_div(2'd0, 32'd7, 32'hFFFF_FFFE);
        chk("div_7_n2_lo", lo, 32'hFFFF_FFFD);
        chk("div_7_n2_hi", hi, 32'd1);
        chk("div_7_n2_divb", div_b, 32'd2);

        // Divide by zero: one-cycle pulse, no divider activity, hi/lo retained.
        issue(2'd0, 32'd5, 32'd0);
        zero_seen = 1'b0; go_seen = 1'b0;
        @(negedge clk);
        chk("dz_pulse", 32'(div_zero), 1);
        chk("dz_busy", 32'(busy), 0);
        go_seen = div_go;
        @(negedge clk);
        chk("dz_pulse_end", 32'(div_zero), 0);
        go_seen = go_seen | div_go;
        chk("dz_go", 32'(go_seen), 0);
        chk("dz_lo", lo, 32'hFFFF_FFFD);
        chk("dz_hi", hi, 32'd1);

        issue(2'd0, 32'h8000_0000, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("ovf_zero", 32'(div_zero), 0);
        wait_done();
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'd0);

        // MTHI while busy must be dropped.
        issue(2'd1, 32'd100, 32'd7);
        @(negedge clk);
        op = 2'd2; op_a = 32'hDEAD_BEEF; op_valid = 1'b1;
        repeat (3) @(negedge clk);
        op_valid = 1'b0;
        wait_done();
        chk("mthi_busy_hi", hi, 32'd2);
        chk("mthi_busy_lo", lo, 32'd14);

        issue(2'd2, 32'hDEAD_BEEF, 32'd0);
        @(negedge clk);
        chk("mthi_hi", hi, 32'hDEAD_BEEF);
        chk("mthi_busy", 32'(busy), 0);
        chk("mthi_lo_kept", lo, 32'd14);

        issue(2'd3, 32'h1234_5678, 32'd0);
        @(negedge clk);
        chk("mtlo_lo", lo, 32'h1234_5678);
        chk("mtlo_hi_kept", hi, 32'hDEAD_BEEF);

        // Reset 10 cycles into a divide.
        issue(2'd1, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        chk("mid_busy_pre", 32'(busy), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_go", 32'(div_go), 0);
        chk("mid_rst_hi", hi, 0);
        chk("mid_rst_lo", lo, 0);
        chk("mid_rst_diva", div_a, 0);
        chk("mid_rst_divb", div_b, 0);
        @(negedge clk);
        reset = 1'b0;

        do_div(2'd1, 32'd9, 32'd3);
        chk("post_busy_cyc", busy_cyc, 34);
        chk("post_lo", lo, 32'd3);
        chk("post_hi", hi, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/div_seq_ctrl.md
# div_seq_ctrl

Sequencer that owns the architectural HI/LO registers and drives the shared iterative unsigned divider for DIV, DIVU, MTHI and MTLO. It sits between the CPU control unit and the divider instance.
- For a divide it latches the operands and converts signed operands to magnitudes.
- It holds the divider enable for exactly the required number of cycles and stalls the pipeline meanwhile.
- It applies the sign correction to the result and writes LO = quotient, HI = remainder.

## Interface
Parameters:
- DIV_ITERS, 32, divider iteration count. The divider enable is held for DIV_ITERS+1 edges: 1 load edge plus the iteration edges.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high
- op_valid  in  1  request strobe, sampled only in IDLE
- op  in  2  operation: 0 = DIV, 1 = DIVU, 2 = MTHI, 3 = MTLO
- op_a  in  32  dividend / MTHI / MTLO source
- op_b  in  32  divisor
- busy  out  1  stall request; high while a divide is in flight
- div_zero  out  1  one-cycle pulse when a divide is issued with op_b == 0
- hi  out  32  HI register (remainder)
- lo  out  32  LO register (quotient)
- div_go  out  1  divider enable; combinational, equals (state == RUN)
- div_a  out  32  dividend magnitude to the divider (registered)
- div_b  out  32  divisor magnitude to the divider (registered)
- div_quo  in  32  divider quotient
- div_rem  in  32  divider remainder
- div_ok  in  1  divider idle/result-ready flag

## Operation
States: IDLE, RUN, WAIT.

IDLE:
- op_valid with MTHI or MTLO: write op_a into hi or lo at that edge. Stay in IDLE; busy stays 0.
- op_valid with DIV/DIVU and op_b == 0: pulse div_zero for one cycle. hi/lo unchanged, no divider activity, stay in IDLE.
- op_valid with DIV/DIVU and op_b != 0:
  - Latch neg_q = signed & (a[31] ^ b[31]) and neg_r = signed & a[31].
  - Latch div_a = signed & a[31] ? -a : a, and div_b likewise from b.
  - Clear cnt and go to RUN.
  - Unsigned ops never negate.

RUN:
- div_go = 1 and cnt increments each edge.
- At the edge where cnt == DIV_ITERS, go to WAIT.

WAIT:
- div_go = 0.
- When div_ok == 1:
  - lo <= neg_q ? -div_quo : div_quo
  - hi <= neg_r ? -div_rem : div_rem
  - go to IDLE.
- If div_ok == 0, stay in WAIT. This cannot happen with a conforming divider.

General rules:
- busy = (state != IDLE).
- op_valid while busy is ignored; the requester is stalled by busy and re-presents the request.
- Arithmetic is 32-bit two's complement with wrap. 0x80000000 / 0xFFFFFFFF under DIV gives lo = 0x80000000, hi = 0; no exception is raised.

## Timing
- Reset: hi = lo = 0, div_a = div_b = 0, state IDLE, cnt = 0, busy = 0, div_go = 0, div_zero = 0.
- Reset mid-divide returns everything to reset values immediately. The divider shares the same reset.
- Divide issue edge E0: busy rises after E0.
- div_go is sampled high by the divider at edges E1..E(DIV_ITERS+1), i.e. E1..E33.
- div_go must be low at edge E34 so the divider does not reload.
- hi/lo are written at E34; busy falls after E34. This is 34 busy cycles.
- div_zero is asserted in the cycle after the issue edge, for exactly one cycle.
- MTHI/MTLO: the value is visible on hi/lo the cycle after the issue edge.

## Structure
- Shared package holds:
  - op encodings (OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO)
  - state enum (IDLE, RUN, WAIT)
  - DIV_ITERS
- One natural sub-module: div_sign_fix. It is combinational and maps (div_quo, div_rem, neg_q, neg_r) to (q_out, r_out).
- The divider itself is instanced beside this block at the top level, not inside it.

## Test plan
- DIVU a = 100, b = 7 -> busy high for exactly 34 cycles, div_go high for 33 cycles; then lo = 14, hi = 2.
- DIV a = 0xFFFFFFF9 (-7), b = 2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1); DIV 7 / -2 -> lo = 0xFFFFFFFD, hi = 1.
- DIV a = 5, b = 0 -> div_zero pulses one cycle, div_go never rises, busy stays 0, hi/lo keep prior values.
- DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0, div_zero = 0.
- MTHI 0xDEADBEEF issued while busy -> ignored. The same MTHI issued in IDLE -> hi = 0xDEADBEEF the next cycle.
- Reset asserted 10 cycles into a divide -> all outputs zero, div_go low. A following DIVU 9 / 3 completes normally with lo = 3, hi = 0.
